// File: rtl/parking_gate_arbiter.sv
// parking_gate_arbiter: shares one barrier gate between entry and exit
// queues with sensor debouncing, round-robin grant and gate sequencing.
module parking_gate_arbiter #(
    parameter int SPOT_W       = 4,
    parameter int DEB_CYCLES   = 4,
    parameter int PASS_TIMEOUT = 64,
    parameter int CLOSE_CYCLES = 8
) (
    input  logic              clk_in,
    input  logic              reset,
    input  logic              entry_sense,
    input  logic              exit_sense,
    input  logic              pass_sense,
    input  logic [SPOT_W-1:0] spots,
    output logic              gate_open,
    output logic [1:0]        grant,
    output logic              car_enter,
    output logic              car_exit,
    output logic              full,
    output logic              timeout_err
);

    localparam int DW = $clog2(DEB_CYCLES + 1);
    localparam int TMAX =
        (PASS_TIMEOUT > CLOSE_CYCLES) ? PASS_TIMEOUT : CLOSE_CYCLES;
    localparam int TW = $clog2(TMAX + 1);
    localparam logic [DW-1:0] DEB_LAST = DW'(DEB_CYCLES - 1);
    localparam logic [TW-1:0] PASS_LAST = TW'(PASS_TIMEOUT - 1);
    localparam logic [TW-1:0] CLOSE_LAST = TW'(CLOSE_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE,
        WAIT_PASS,
        WAIT_CLEAR,
        CLOSE
    } state_t;

    logic [2:0] raw;
    logic [2:0] sync1;
    logic [2:0] sync2;
    logic [2:0] db;

    logic entry_db;
    logic exit_db;
    logic pass_db;

    state_t     state;
    state_t     state_d;
    logic [TW-1:0] timer;
    logic [TW-1:0] timer_d;
    logic       last_ex;
    logic       last_ex_d;
    logic [1:0] grant_q;
    logic [1:0] grant_d;
    logic       gate_q;
    logic       gate_d;
    logic       enter_q;
    logic       enter_d;
    logic       exit_q;
    logic       exit_d;
    logic       to_q;
    logic       to_d;
    logic       full_q;

    logic req_en;
    logic req_ex;
    logic pick_ex;

    assign raw = {pass_sense, exit_sense, entry_sense};

    // Bring the raw asynchronous sensors into the clock domain
    always_ff @(posedge clk_in or negedge reset) begin
        if (!reset) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
        end
    end

    for (genvar i = 0; i < 3; i++) begin : g_deb
        logic [DW-1:0] cnt;
        logic          db_q;

        // Flip the level only after DEB_CYCLES disagreeing samples in a row
        always_ff @(posedge clk_in or negedge reset) begin
            if (!reset) begin
                cnt  <= '0;
                db_q <= 1'b0;
            end else if (sync2[i] == db_q) begin
                cnt <= '0;
            end else if (cnt == DEB_LAST) begin
                cnt  <= '0;
                db_q <= sync2[i];
            end else begin
                cnt <= cnt + DW'(1);
            end
        end

        assign db[i] = db_q;
    end

    assign entry_db = db[0];
    assign exit_db  = db[1];
    assign pass_db  = db[2];

    assign req_en  = entry_db & (spots != '0);
    assign req_ex  = exit_db;
    assign pick_ex = req_ex & (~req_en | ~last_ex);

    // State, timer, owner history and all outputs are registered here
    always_ff @(posedge clk_in or negedge reset) begin
        if (!reset) begin
            state   <= IDLE;
            timer   <= '0;
            last_ex <= 1'b0;
            grant_q <= 2'b00;
            gate_q  <= 1'b0;
            enter_q <= 1'b0;
            exit_q  <= 1'b0;
            to_q    <= 1'b0;
            full_q  <= 1'b0;
        end else begin
            state   <= state_d;
            timer   <= timer_d;
            last_ex <= last_ex_d;
            grant_q <= grant_d;
            gate_q  <= gate_d;
            enter_q <= enter_d;
            exit_q  <= exit_d;
            to_q    <= to_d;
            full_q  <= (spots == '0);
        end
    end

    // Gate sequencing: grant, wait for the car, wait for it to clear, close
    always_comb begin
        state_d   = state;
        timer_d   = timer;
        last_ex_d = last_ex;
        grant_d   = grant_q;
        gate_d    = gate_q;
        enter_d   = 1'b0;
        exit_d    = 1'b0;
        to_d      = 1'b0;
        unique case (state)
            IDLE: begin
                if (req_en | req_ex) begin
                    grant_d   = pick_ex ? 2'b10 : 2'b01;
                    gate_d    = 1'b1;
                    last_ex_d = pick_ex;
                    timer_d   = '0;
                    state_d   = WAIT_PASS;
                end
            end
            WAIT_PASS: begin
                if (pass_db) begin
                    state_d = WAIT_CLEAR;
                end else if (timer == PASS_LAST) begin
                    to_d    = 1'b1;
                    gate_d  = 1'b0;
                    grant_d = 2'b00;
                    timer_d = '0;
                    state_d = CLOSE;
                end else begin
                    timer_d = timer + TW'(1);
                end
            end
            WAIT_CLEAR: begin
                if (!pass_db) begin
                    enter_d = grant_q[0];
                    exit_d  = grant_q[1];
                    gate_d  = 1'b0;
                    grant_d = 2'b00;
                    timer_d = '0;
                    state_d = CLOSE;
                end
            end
            CLOSE: begin
                if (timer == CLOSE_LAST) begin
                    timer_d = '0;
                    state_d = IDLE;
                end else begin
                    timer_d = timer + TW'(1);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign gate_open   = gate_q;
    assign grant       = grant_q;
    assign car_enter   = enter_q;
    assign car_exit    = exit_q;
    assign full        = full_q;
    assign timeout_err = to_q;

endmodule

// File: tb/tb_parking_gate_arbiter.sv
// tb_parking_gate_arbiter: directed scenarios plus random sensor traffic,
// all checked against a timestamp-based behavioural model.
module tb_parking_gate_arbiter;

    localparam int SPOT_W = 4;
    localparam int DEB    = 4;
    localparam int PT     = 64;
    localparam int CC     = 8;

    localparam int PH_IDLE  = 0;
    localparam int PH_PASS  = 1;
    localparam int PH_CLEAR = 2;
    localparam int PH_CLOSE = 3;

    logic              clk_in = 1'b0;
    logic              reset = 1'b0;
    logic              entry_sense = 1'b0;
    logic              exit_sense = 1'b0;
    logic              pass_sense = 1'b0;
    logic [SPOT_W-1:0] spots = '0;
    logic              gate_open;
    logic [1:0]        grant;
    logic              car_enter;
    logic              car_exit;
    logic              full;
    logic              timeout_err;

    int checks = 0;
    int failures = 0;

    parking_gate_arbiter #(
        .SPOT_W(SPOT_W),
        .DEB_CYCLES(DEB),
        .PASS_TIMEOUT(PT),
        .CLOSE_CYCLES(CC)
    ) dut (
        .clk_in(clk_in),
        .reset(reset),
        .entry_sense(entry_sense),
        .exit_sense(exit_sense),
        .pass_sense(pass_sense),
        .spots(spots),
        .gate_open(gate_open),
        .grant(grant),
        .car_enter(car_enter),
        .car_exit(car_exit),
        .full(full),
        .timeout_err(timeout_err)
    );

    always #5 clk_in = ~clk_in;

    bit [15:0] m_hist [3];
    bit [2:0]  m_db = '0;
    int        m_phase = PH_IDLE;
    int        m_cyc = 0;
    int        m_deadline = 0;
    int        m_close_end = 0;
    bit        m_last_ex = 1'b0;
    bit        m_gate = 1'b0;
    bit [1:0]  m_grant = 2'b00;
    bit        m_enter = 1'b0;
    bit        m_exit = 1'b0;
    bit        m_full = 1'b0;
    bit        m_to = 1'b0;

    logic [6:0] dut_v;
    logic [6:0] mdl_v;
    assign dut_v = {gate_open, grant, car_enter, car_exit, full, timeout_err};
    assign mdl_v = {m_gate, m_grant, m_enter, m_exit, m_full, m_to};

    task automatic model_reset();
        for (int k = 0; k < 3; k++) m_hist[k] = '0;
        m_db = '0;
        m_phase = PH_IDLE;
        m_last_ex = 1'b0;
        m_gate = 1'b0;
        m_grant = 2'b00;
        m_enter = 1'b0;
        m_exit = 1'b0;
        m_full = 1'b0;
        m_to = 1'b0;
    endtask

    // Sensor level flips once the last DEB synchronized samples all
    // disagree with it; the gate phases run on absolute-cycle deadlines.
    task automatic model_step();
        bit re;
        bit rx;
        bit pe;
        bit ok;
        bit [2:0] r;
        r = {pass_sense, exit_sense, entry_sense};
        m_cyc++;
        m_enter = 1'b0;
        m_exit = 1'b0;
        m_to = 1'b0;
        m_full = (spots == 0);
        case (m_phase)
            PH_IDLE: begin
                re = m_db[0] && (spots != 0);
                rx = m_db[1];
                if (re || rx) begin
                    if (re && rx) pe = !m_last_ex;
                    else pe = rx;
                    m_grant = pe ? 2'b10 : 2'b01;
                    m_gate = 1'b1;
                    m_last_ex = pe;
                    m_deadline = m_cyc + PT;
                    m_phase = PH_PASS;
                end
            end
            PH_PASS: begin
                if (m_db[2]) begin
                    m_phase = PH_CLEAR;
                end else if (m_cyc == m_deadline) begin
                    m_to = 1'b1;
                    m_gate = 1'b0;
                    m_grant = 2'b00;
                    m_close_end = m_cyc + CC;
                    m_phase = PH_CLOSE;
                end
            end
            PH_CLEAR: begin
                if (!m_db[2]) begin
                    m_enter = m_grant[0];
                    m_exit = m_grant[1];
                    m_gate = 1'b0;
                    m_grant = 2'b00;
                    m_close_end = m_cyc + CC;
                    m_phase = PH_CLOSE;
                end
            end
            default: begin
                if (m_cyc == m_close_end) m_phase = PH_IDLE;
            end
        endcase
        for (int k = 0; k < 3; k++) begin
            ok = 1'b1;
            for (int j = 1; j <= DEB; j++) begin
                if (m_hist[k][j] == m_db[k]) ok = 1'b0;
            end
            if (ok) m_db[k] = !m_db[k];
            m_hist[k] = {m_hist[k][14:0], r[k]};
        end
    endtask

    // Reference model advances on the same edges as the design
    always @(posedge clk_in or negedge reset) begin
        if (!reset) model_reset();
        else model_step();
    end

    task automatic do_reset();
        reset = 1'b0;
        entry_sense = 1'b0;
        exit_sense = 1'b0;
        pass_sense = 1'b0;
        repeat (3) @(negedge clk_in);
        reset = 1'b1;
    endtask

    task automatic test_reset();
        bit seen;
        do_reset();
        reset = 1'b0;
        #1;
        checks++;
        if (dut_v !== 7'b0) begin
            failures++;
            $display("FAIL reset_outputs dut=%b want=0000000", dut_v);
        end
        @(negedge clk_in);
        reset = 1'b1;
        spots = 4'd3;
        exit_sense = 1'b1;
        seen = 1'b0;
        for (int c = 0; c < 20 && !seen; c++) begin
            @(negedge clk_in);
            checks++;
            if (dut_v !== mdl_v) begin
                failures++;
                $display("FAIL reset_pre c=%0d dut=%b model=%b", c, dut_v, mdl_v);
            end
            seen = (grant != 2'b00);
        end
        checks++;
        if (!seen) begin
            failures++;
            $display("FAIL reset_grant dut=%b want=10", grant);
        end
        #2 reset = 1'b0;
        #1;
        checks++;
        if ({gate_open, grant} !== 3'b000) begin
            failures++;
            $display("FAIL reset_async dut=%b want=000", {gate_open, grant});
        end
        exit_sense = 1'b0;
        repeat (3) @(negedge clk_in);
        reset = 1'b1;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk_in);
            checks++;
            if (dut_v !== mdl_v || {car_enter, car_exit, timeout_err, gate_open} !== 4'b0) begin
                failures++;
                $display("FAIL reset_post c=%0d dut=%b model=%b", c, dut_v, mdl_v);
            end
        end
    endtask

    task automatic test_single_entry();
        int pulses;
        int after;
        bit done;
        do_reset();
        spots = 4'd5;
        repeat (5) @(negedge clk_in);
        entry_sense = 1'b1;
        for (int i = 1; i <= 7; i++) begin
            @(negedge clk_in);
            checks++;
            if (dut_v !== mdl_v || grant !== ((i == 7) ? 2'b01 : 2'b00)
                || gate_open !== (i == 7)) begin
                failures++;
                $display("FAIL entry_latency i=%0d dut=%b model=%b", i, dut_v, mdl_v);
            end
        end
        entry_sense = 1'b0;
        pass_sense = 1'b1;
        pulses = 0;
        after = 0;
        done = 1'b0;
        for (int c = 0; c < 60; c++) begin
            @(negedge clk_in);
            checks++;
            if (dut_v !== mdl_v) begin
                failures++;
                $display("FAIL entry_seq c=%0d dut=%b model=%b", c, dut_v, mdl_v);
            end
            if (c == 7) pass_sense = 1'b0;
            if (done && gate_open) after++;
            if (car_enter) begin
                pulses++;
                done = 1'b1;
                checks++;
                if (gate_open !== 1'b0) begin
                    failures++;
                    $display("FAIL entry_gate_drop dut=%b want=0", gate_open);
                end
            end
        end
        checks++;
        if (pulses != 1 || after != 0) begin
            failures++;
            $display("FAIL entry_pulse pulses=%0d want=1 reopen=%0d want=0", pulses, after);
        end
    endtask

    task automatic test_contention();
        logic [1:0] owners [4];
        logic [1:0] want [4];
        logic [1:0] prev;
        int n;
        int pcnt;
        want[0] = 2'b10;
        want[1] = 2'b01;
        want[2] = 2'b10;
        want[3] = 2'b01;
        do_reset();
        spots = 4'd5;
        entry_sense = 1'b1;
        exit_sense = 1'b1;
        n = 0;
        pcnt = 0;
        prev = 2'b00;
        for (int c = 0; c < 400 && n < 4; c++) begin
            @(negedge clk_in);
            checks++;
            if (dut_v !== mdl_v) begin
                failures++;
                $display("FAIL contention c=%0d dut=%b model=%b", c, dut_v, mdl_v);
            end
            if (grant != 2'b00 && prev == 2'b00) begin
                owners[n] = grant;
                n++;
                pcnt = 8;
            end
            prev = grant;
            pass_sense = (pcnt > 0);
            if (pcnt > 0) pcnt--;
        end
        checks++;
        if (n != 4) begin
            failures++;
            $display("FAIL contention_count grants=%0d want=4", n);
        end
        for (int i = 0; i < n; i++) begin
            checks++;
            if (owners[i] !== want[i]) begin
                failures++;
                $display("FAIL contention_order i=%0d dut=%b want=%b", i, owners[i], want[i]);
            end
        end
    endtask

    task automatic test_full_lot();
        logic [1:0] first;
        logic [1:0] prev;
        int bad;
        int pcnt;
        bit got;
        do_reset();
        spots = 4'd0;
        entry_sense = 1'b1;
        bad = 0;
        for (int c = 0; c < 30; c++) begin
            @(negedge clk_in);
            checks++;
            if (dut_v !== mdl_v) begin
                failures++;
                $display("FAIL full_wait c=%0d dut=%b model=%b", c, dut_v, mdl_v);
            end
            if (grant != 2'b00) bad++;
        end
        checks++;
        if (bad != 0 || full !== 1'b1) begin
            failures++;
            $display("FAIL full_block grants=%0d want=0 full=%b want=1", bad, full);
        end
        exit_sense = 1'b1;
        first = 2'b00;
        prev = 2'b00;
        pcnt = 0;
        got = 1'b0;
        for (int c = 0; c < 200 && !got; c++) begin
            @(negedge clk_in);
            checks++;
            if (dut_v !== mdl_v) begin
                failures++;
                $display("FAIL full_exit c=%0d dut=%b model=%b", c, dut_v, mdl_v);
            end
            if (grant != 2'b00 && prev == 2'b00) begin
                if (first == 2'b00) first = grant;
                exit_sense = 1'b0;
                pcnt = 8;
            end
            got = car_exit;
            prev = grant;
            pass_sense = (pcnt > 0);
            if (pcnt > 0) pcnt--;
        end
        checks++;
        if (first !== 2'b10 || !got) begin
            failures++;
            $display("FAIL full_exit_served owner=%b want=10 pulse=%b want=1", first, got);
        end
        spots = 4'd1;
        first = 2'b00;
        for (int c = 0; c < 60 && first == 2'b00; c++) begin
            @(negedge clk_in);
            checks++;
            if (dut_v !== mdl_v) begin
                failures++;
                $display("FAIL full_refill c=%0d dut=%b model=%b", c, dut_v, mdl_v);
            end
            first = grant;
        end
        checks++;
        if (first !== 2'b01) begin
            failures++;
            $display("FAIL full_entry_after owner=%b want=01", first);
        end
    endtask

    task automatic test_timeout();
        int g;
        int t;
        int tos;
        int cars;
        do_reset();
        spots = 4'd5;
        entry_sense = 1'b1;
        g = -1;
        t = -1;
        tos = 0;
        cars = 0;
        for (int c = 0; c < 120; c++) begin
            @(negedge clk_in);
            checks++;
            if (dut_v !== mdl_v) begin
                failures++;
                $display("FAIL timeout_seq c=%0d dut=%b model=%b", c, dut_v, mdl_v);
            end
            if (g < 0 && grant != 2'b00) begin
                g = c;
                entry_sense = 1'b0;
            end
            if (timeout_err) begin
                tos++;
                if (t < 0) t = c;
            end
            if (car_enter || car_exit) cars++;
        end
        checks++;
        if (g < 0 || t - g != PT || tos != 1 || cars != 0 || gate_open !== 1'b0) begin
            failures++;
            $display("FAIL timeout_timing delay=%0d want=%0d pulses=%0d want=1 cars=%0d want=0",
                     t - g, PT, tos, cars);
        end
    endtask

    task automatic test_glitch_long();
        int bad;
        int pulses;
        bit seen;
        do_reset();
        spots = 4'd5;
        entry_sense = 1'b1;
        bad = 0;
        for (int c = 0; c < 30; c++) begin
            @(negedge clk_in);
            checks++;
            if (dut_v !== mdl_v) begin
                failures++;
                $display("FAIL glitch c=%0d dut=%b model=%b", c, dut_v, mdl_v);
            end
            if (c == 1) entry_sense = 1'b0;
            if (grant != 2'b00) bad++;
        end
        checks++;
        if (bad != 0) begin
            failures++;
            $display("FAIL glitch_grant grants=%0d want=0", bad);
        end
        entry_sense = 1'b1;
        seen = 1'b0;
        for (int c = 0; c < 20 && !seen; c++) begin
            @(negedge clk_in);
            seen = (grant == 2'b01);
        end
        checks++;
        if (!seen) begin
            failures++;
            $display("FAIL long_grant dut=%b want=01", grant);
        end
        entry_sense = 1'b0;
        pass_sense = 1'b1;
        bad = 0;
        for (int c = 0; c < 500; c++) begin
            @(negedge clk_in);
            if (dut_v !== mdl_v || gate_open !== 1'b1 || timeout_err !== 1'b0) bad++;
        end
        checks++;
        if (bad != 0) begin
            failures++;
            $display("FAIL long_hold bad_cycles=%0d want=0", bad);
        end
        pass_sense = 1'b0;
        pulses = 0;
        for (int c = 0; c < 30; c++) begin
            @(negedge clk_in);
            checks++;
            if (dut_v !== mdl_v) begin
                failures++;
                $display("FAIL long_release c=%0d dut=%b model=%b", c, dut_v, mdl_v);
            end
            if (car_enter) pulses++;
        end
        checks++;
        if (pulses != 1 || gate_open !== 1'b0) begin
            failures++;
            $display("FAIL long_pulse pulses=%0d want=1 gate=%b want=0", pulses, gate_open);
        end
    endtask

    task automatic test_random();
        bit prev_p;
        bit cur_p;
        do_reset();
        spots = 4'd2;
        prev_p = 1'b0;
        for (int c = 0; c < 4000; c++) begin
            @(negedge clk_in);
            checks++;
            if (dut_v !== mdl_v) begin
                failures++;
                $display("FAIL random c=%0d dut=%b model=%b", c, dut_v, mdl_v);
            end
            cur_p = car_enter | car_exit | timeout_err;
            checks++;
            if ($countones({car_enter, car_exit, timeout_err}) > 1 || (cur_p && prev_p)) begin
                failures++;
                $display("FAIL random_excl c=%0d pulses=%b want=onehot_nonconsec",
                         c, {car_enter, car_exit, timeout_err});
            end
            prev_p = cur_p;
            if ($urandom_range(0, 9) == 0) entry_sense = ~entry_sense;
            if ($urandom_range(0, 9) == 0) exit_sense = ~exit_sense;
            if ($urandom_range(0, 7) == 0) pass_sense = ~pass_sense;
            if ($urandom_range(0, 39) == 0) spots = SPOT_W'($urandom_range(0, 3));
        end
    endtask

    initial begin
        test_reset();
        test_single_entry();
        test_contention();
        test_full_lot();
        test_timeout();
        test_glitch_long();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/parking_gate_arbiter.md
# parking_gate_arbiter

Shares the single barrier gate of the car-park lane between the entry and exit queues. It debounces the raw car-presence sensors, grants the gate to one requester at a time, and sequences the barrier through open, wait-for-car and close. It issues the one-cycle `car_enter`/`car_exit` pulses that drive the `ParkingSystem` occupancy counter, and refuses entry while `spots` reads zero.

## Interface
- `SPOT_W`, 4: width of the free-spot count from `ParkingSystem`.
- `DEB_CYCLES`, 4: consecutive stable synchronized samples needed to change a debounced sensor (≥2).
- `PASS_TIMEOUT`, 64: cycles the gate waits for a car to reach the pass sensor before aborting.
- `CLOSE_CYCLES`, 8: cycles the barrier is held closed before a new grant.

Ports:
- `clk_in` in 1: single clock; all logic on its rising edge.
- `reset` in 1: asynchronous, active-low reset.
- `entry_sense` in 1: raw, asynchronous car-present sensor at the entry queue.
- `exit_sense` in 1: raw, asynchronous car-present sensor at the exit queue.
- `pass_sense` in 1: raw, asynchronous car-under-barrier sensor.
- `spots` in SPOT_W: free spots reported by `ParkingSystem`.
- `gate_open` out 1: barrier open command.
- `grant` out 2: one-hot owner, {exit, entry}; 2'b00 when idle.
- `car_enter` out 1: one-cycle pulse when an entering car has cleared the barrier.
- `car_exit` out 1: one-cycle pulse when an exiting car has cleared the barrier.
- `full` out 1: registered copy of (`spots` == 0).
- `timeout_err` out 1: one-cycle pulse on a pass timeout.

## Operation
- **Reset values.** All outputs are 0, the FSM is IDLE, debounced sensors are 0 and `last_grant` = entry.
- **Input conditioning.** Each sense input goes through a 2-flop synchronizer and then a debounce counter.
  - The counter increments while the synchronized value ≠ the debounced value, and clears otherwise.
  - The debounced value takes the new level when the count reaches `DEB_CYCLES`.
- **Requests.**
  - `req_en` = `entry_db` & (`spots` ≠ 0).
  - `req_ex` = `exit_db`.
  - `spots` is sampled only in IDLE.
- **IDLE.**
  - With a single request, grant it.
  - With both requests, grant the lane ≠ `last_grant`. After reset this means exit wins the first tie.
  - On a grant: set `grant`, set `gate_open`, update `last_grant`, clear the timer, go to WAIT_PASS.
- **WAIT_PASS.**
  - If `pass_db` = 1, go to WAIT_CLEAR.
  - Otherwise, when the timer reaches `PASS_TIMEOUT`, pulse `timeout_err`, drop `gate_open` and `grant`, and go to CLOSE. No count pulse is issued.
- **WAIT_CLEAR.**
  - Wait with no timeout; the barrier never closes on a car.
  - When `pass_db` = 0: pulse `car_enter` (entry grant) or `car_exit` (exit grant), drop `gate_open` and `grant`, and go to CLOSE.
- **CLOSE.** Hold for `CLOSE_CYCLES` cycles, then go to IDLE.
  - A car still present at the sensor re-requests normally in IDLE.
  - Round-robin then alternates lanes under sustained contention.
- **Boundary conditions.**
  - Entry requests are ignored while `spots` = 0. Exit requests are always served.
  - A change in `spots` after a grant does not revoke it.
  - A sensor dropping after a grant does not abort the sequence; only the timeout does.
  - `reset` asserted mid-sequence forces `gate_open` = 0 and `grant` = 0 immediately, and no pulse is issued.
- **Output exclusivity.** `car_enter`, `car_exit` and `timeout_err` are mutually exclusive and never high for two consecutive cycles.

## Timing
- A raw edge sampled at edge N appears on the synchronizer output at N+2 and on the debounced value at N+2+`DEB_CYCLES`.
  - `grant`/`gate_open` are registered at N+3+`DEB_CYCLES` (IDLE, no contention).
- `pass_db` = 1 at edge M (in WAIT_PASS) moves the FSM to WAIT_CLEAR at M+1.
- `pass_db` = 0 at edge K (in WAIT_CLEAR) gives a count pulse high for edges K+1..K+2 exclusive, i.e. one cycle. `gate_open` falls at the same edge the pulse rises.
- The timeout fires when the timer reaches `PASS_TIMEOUT` cycles after `gate_open` rose, without `pass_db`.
- The minimum grant-to-grant interval is 2 + `CLOSE_CYCLES` plus the debounced pass time.
- `full` lags `spots` by one cycle.

## Test plan
- **Reset.** `reset`=0 during activity → all outputs 0 asynchronously; after release, IDLE with no pulses.
- **Single entry.** `spots`=5, `entry_sense` high → `gate_open`/`grant`=01 at 3+4=7 cycles after the raw edge. `pass_sense` pulse → exactly one `car_enter` cycle, `gate_open` drops, and 8 closed cycles follow.
- **Contention.** `entry_sense` and `exit_sense` high together from reset → exit granted first, then entry; four back-to-back cycles alternate ex/en/ex/en.
- **Full lot.** `spots`=0, `entry_sense` high → no grant and `full`=1; `exit_sense` → exit served; after `spots`=1, entry is granted.
- **Timeout.** Grant with no `pass_sense` → `timeout_err` for one cycle after 64 cycles, no `car_enter`, gate closes.
- **Glitch and long occupancy.** A 2-cycle `entry_sense` glitch → no grant. `pass_sense` held for 500 cycles → `gate_open` stays 1 with no timeout, and one pulse occurs on release.
